freq_error_meter: RTL and testbench

- N-channel gated frequency meter/error calculator in the clk_ocxo domain.
- Each channel supplies a one-cycle event strobe, already synchronised to clk_ocxo upstream (e.g. divided oscillator edge).
- Over a programmable gate of reference cycles, the block counts events per channel, snapshots the counts, and streams per-channel count, signed error vs. expected and fault flags over a valid/ready port.
- Supports single-shot and continuous gating, saturating counters and overrun detection.

---
 rtl/freq_meter_pkg.sv | 19 +
 rtl/freq_ch_counter.sv | 72 +++++++
 rtl/freq_error_meter.sv | 167 ++++++++++++++++
 tb/tb_freq_error_meter.sv | 287 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/freq_meter_pkg.sv
// Shared definitions for the gated frequency/error meter.
// Contents: FSM state encoding, channel-index width helper, error width extension.
package freq_meter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_GATE = 2'd1,
        ST_HOLD = 2'd2
    } state_t;

    // Error is one bit wider than the count so the signed difference never wraps.
    localparam int unsigned ERR_EXTRA_W = 1;

    // Width of a channel index; at least one bit even for a single channel.
    function automatic int unsigned ch_idx_w(input int unsigned n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/freq_ch_counter.sv
// One measurement channel: saturating live event counter plus snapshot register.
// Ports:
//   clk, rst_n    clock, async active-low reset
//   clr           synchronous clear of live count, overflow and snapshot
//   cnt_en        channel is inside a gate; inc is counted
//   inc           event strobe
//   gate_end      last gate edge; live count/overflow restart from zero
//   load          copy this edge's final count/overflow into the snapshot
//   shd_cnt       snapshot count
//   shd_ovf       snapshot overflow flag
module freq_ch_counter #(
    parameter int unsigned BIT_CNT = 25
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               clr,
    input  logic               cnt_en,
    input  logic               inc,
    input  logic               gate_end,
    input  logic               load,
    output logic [BIT_CNT-1:0] shd_cnt,
    output logic               shd_ovf
);

    localparam logic [BIT_CNT-1:0] CNT_MAX = '1;

    logic [BIT_CNT-1:0] cnt_q;
    logic [BIT_CNT-1:0] cnt_nxt;
    logic               ovf_q;
    logic               ovf_nxt;

    // Next count including this edge's event; an event arriving at full scale is lost and flagged.
    always_comb begin
        cnt_nxt = cnt_q;
        ovf_nxt = ovf_q;
        if (cnt_en && inc) begin
            if (cnt_q == CNT_MAX) begin
                ovf_nxt = 1'b1;
            end else begin
                cnt_nxt = cnt_q + 1'b1;
            end
        end
    end

    // Live counter and snapshot registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q   <= '0;
            ovf_q   <= 1'b0;
            shd_cnt <= '0;
            shd_ovf <= 1'b0;
        end else if (clr) begin
            cnt_q   <= '0;
            ovf_q   <= 1'b0;
            shd_cnt <= '0;
            shd_ovf <= 1'b0;
        end else begin
            if (gate_end) begin
                cnt_q <= '0;
                ovf_q <= 1'b0;
            end else begin
                cnt_q <= cnt_nxt;
                ovf_q <= ovf_nxt;
            end
            if (load) begin
                shd_cnt <= cnt_nxt;
                shd_ovf <= ovf_nxt;
            end
        end
    end

endmodule

// File: rtl/freq_error_meter.sv
// N-channel gated frequency meter: counts per-channel events over a gate of
// reference cycles, snapshots them and streams count/error/fault per channel.
// Ports:
//   clk_ocxo, rst        reference clock, async active-low reset
//   EN                   enable; low aborts and clears everything but the state register reset
//   mode_cont, start     gate mode (sampled at start), start request
//   ev_in                per-channel one-cycle event strobes
//   res_valid/res_ready  result stream handshake
//   res_ch, res_count    channel index and snapshot count of the current beat
//   res_error, res_fault signed count-EXPECTED and tolerance/overflow fault
//   res_ovf              channel counter saturated in that gate
//   busy, overrun        not idle; sticky dropped-snapshot flag
module freq_error_meter
    import freq_meter_pkg::*;
#(
    parameter  int unsigned N_CH        = 15,
    parameter  int unsigned BIT_CNT     = 25,
    parameter  int unsigned GATE_CYCLES = 16000000,
    parameter  int unsigned EXPECTED    = 16000000,
    parameter  int unsigned TOL         = 1,
    localparam int unsigned CH_W        = ch_idx_w(N_CH),
    localparam int unsigned ERR_W       = BIT_CNT + ERR_EXTRA_W
) (
    input  logic                    clk_ocxo,
    input  logic                    rst,
    input  logic                    EN,
    input  logic                    mode_cont,
    input  logic                    start,
    input  logic [N_CH-1:0]         ev_in,
    output logic                    res_valid,
    input  logic                    res_ready,
    output logic [CH_W-1:0]         res_ch,
    output logic [BIT_CNT-1:0]      res_count,
    output logic signed [ERR_W-1:0] res_error,
    output logic                    res_fault,
    output logic                    res_ovf,
    output logic                    busy,
    output logic                    overrun
);

    localparam int unsigned GATE_W = $clog2(GATE_CYCLES);
    localparam logic signed [ERR_W-1:0] EXP_S = ERR_W'(EXPECTED);
    localparam logic signed [ERR_W-1:0] TOL_S = ERR_W'(TOL);

    state_t              state;
    state_t              state_nxt;
    logic [GATE_W-1:0]   gate_cnt;
    logic                mode_q;
    logic                in_gate;
    logic                gate_end;
    logic                final_acc;
    logic                take;
    logic                drop;
    logic [BIT_CNT-1:0]  shd_cnt [N_CH];
    logic [N_CH-1:0]     shd_ovf;
    logic [BIT_CNT-1:0]  sel_cnt;
    logic                sel_ovf;

    assign in_gate   = EN && (state == ST_GATE);
    assign gate_end  = in_gate && (gate_cnt == GATE_W'(GATE_CYCLES - 1));
    assign final_acc = res_valid && res_ready && (res_ch == CH_W'(N_CH - 1));
    // A final beat accepted on the gate-end edge frees the shadow for the new snapshot.
    assign take      = gate_end && !(res_valid && !final_acc);
    assign drop      = gate_end && res_valid && !final_acc;

    // Per-channel counters.
    for (genvar i = 0; i < N_CH; i++) begin : g_ch
        freq_ch_counter #(
            .BIT_CNT (BIT_CNT)
        ) u_cnt (
            .clk      (clk_ocxo),
            .rst_n    (rst),
            .clr      (!EN),
            .cnt_en   (in_gate),
            .inc      (ev_in[i]),
            .gate_end (gate_end),
            .load     (take),
            .shd_cnt  (shd_cnt[i]),
            .shd_ovf  (shd_ovf[i])
        );
    end

    // Next-state logic.
    always_comb begin
        state_nxt = state;
        if (!EN) begin
            state_nxt = ST_IDLE;
        end else begin
            case (state)
                ST_IDLE: if (start)                 state_nxt = ST_GATE;
                ST_GATE: if (gate_end && !mode_q)   state_nxt = ST_HOLD;
                ST_HOLD: if (final_acc)             state_nxt = ST_IDLE;
                default:                            state_nxt = ST_IDLE;
            endcase
        end
    end

    // State register.
    always_ff @(posedge clk_ocxo or negedge rst) begin
        if (!rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Gate counter, drain sequencing and registered status outputs.
    always_ff @(posedge clk_ocxo or negedge rst) begin
        if (!rst) begin
            gate_cnt  <= '0;
            mode_q    <= 1'b0;
            res_valid <= 1'b0;
            res_ch    <= '0;
            busy      <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            busy <= (state_nxt != ST_IDLE);
            if (!EN) begin
                gate_cnt  <= '0;
                mode_q    <= 1'b0;
                res_valid <= 1'b0;
                res_ch    <= '0;
                overrun   <= 1'b0;
            end else begin
                if ((state == ST_IDLE) && start) begin
                    gate_cnt <= '0;
                    mode_q   <= mode_cont;
                end else if (in_gate) begin
                    gate_cnt <= gate_end ? '0 : gate_cnt + 1'b1;
                end

                if (take) begin
                    res_valid <= 1'b1;
                    res_ch    <= '0;
                end else if (res_valid && res_ready) begin
                    if (final_acc) begin
                        res_valid <= 1'b0;
                        res_ch    <= '0;
                    end else begin
                        res_ch <= res_ch + 1'b1;
                    end
                end

                if (drop) begin
                    overrun <= 1'b1;
                end
            end
        end
    end

    // Result mux from the snapshot; zeroed while no beat is offered.
    always_comb begin
        sel_cnt = '0;
        sel_ovf = 1'b0;
        for (int i = 0; i < N_CH; i++) begin
            if (res_ch == CH_W'(i)) begin
                sel_cnt = shd_cnt[i];
                sel_ovf = shd_ovf[i];
            end
        end
        res_count = res_valid ? sel_cnt : '0;
        res_ovf   = res_valid && sel_ovf;
        res_error = res_valid ? ($signed({1'b0, sel_cnt}) - EXP_S) : '0;
        res_fault = res_valid && (sel_ovf || (res_error > TOL_S) || (res_error < -TOL_S));
    end

endmodule

// File: tb/tb_freq_error_meter.sv
// Self-checking bench for freq_error_meter (N_CH=4, GATE_CYCLES=20, EXPECTED=10, TOL=1).
// A second instance with BIT_CNT=4 covers counter saturation.
module tb_freq_error_meter;

    typedef struct {
        int n   [4];
        bit alt0;
        int cnt [4];
        int err [4];
        bit flt [4];
    } vec_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic              rst, en, mode_cont, start, res_ready;
    logic [3:0]        ev_in;
    logic              res_valid, res_fault, res_ovf, busy, overrun;
    logic [1:0]        res_ch;
    logic [7:0]        res_count;
    logic signed [8:0] res_error;

    logic              s_start;
    logic [3:0]        s_ev;
    logic              s_valid, s_fault, s_ovf, s_busy, s_overrun;
    logic [1:0]        s_ch;
    logic [3:0]        s_count;
    logic signed [4:0] s_error;

    freq_error_meter #(
        .N_CH(4), .BIT_CNT(8), .GATE_CYCLES(20), .EXPECTED(10), .TOL(1)
    ) dut (
        .clk_ocxo(clk), .rst(rst), .EN(en), .mode_cont(mode_cont), .start(start),
        .ev_in(ev_in), .res_valid(res_valid), .res_ready(res_ready), .res_ch(res_ch),
        .res_count(res_count), .res_error(res_error), .res_fault(res_fault),
        .res_ovf(res_ovf), .busy(busy), .overrun(overrun)
    );

    freq_error_meter #(
        .N_CH(4), .BIT_CNT(4), .GATE_CYCLES(20), .EXPECTED(10), .TOL(1)
    ) dut_sat (
        .clk_ocxo(clk), .rst(rst), .EN(en), .mode_cont(mode_cont), .start(s_start),
        .ev_in(s_ev), .res_valid(s_valid), .res_ready(res_ready), .res_ch(s_ch),
        .res_count(s_count), .res_error(s_error), .res_fault(s_fault),
        .res_ovf(s_ovf), .busy(s_busy), .overrun(s_overrun)
    );

    int n_chk  = 0;
    int n_pass = 0;

    logic [3:0] ev_sched [21];
    vec_t       vecs [4];
    vec_t       v_ab;
    vec_t       v_bd;

    task automatic chk(input string name, input int act, input int exp);
        n_chk++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Channel i pulses on gate edges 1..n_i; alt0 makes ch0 pulse on even edges.
    task automatic fill_counts(input int n0, input int n1, input int n2, input int n3, input bit alt0);
        for (int j = 0; j <= 20; j++) begin
            ev_sched[j] = '0;
            if (j >= 1) begin
                ev_sched[j][0] = alt0 ? (j % 2 == 0) : (j <= n0);
                ev_sched[j][1] = (j <= n1);
                ev_sched[j][2] = (j <= n2);
                ev_sched[j][3] = (j <= n3);
            end
        end
    endtask

    // Start edge uses ev_sched[0], then 20 gate edges.
    task automatic run_gate(input bit cont);
        mode_cont = cont;
        start     = 1'b1;
        ev_in     = ev_sched[0];
        tick;
        start = 1'b0;
        for (int j = 1; j <= 20; j++) begin
            ev_in = ev_sched[j];
            tick;
        end
        ev_in = '0;
    endtask

    task automatic drain_expect(input string tag, input vec_t v);
        res_ready = 1'b1;
        for (int b = 0; b < 4; b++) begin
            chk($sformatf("%s b%0d valid", tag, b), int'(res_valid), 1);
            chk($sformatf("%s b%0d ch",    tag, b), int'(res_ch), b);
            chk($sformatf("%s b%0d count", tag, b), int'(res_count), v.cnt[b]);
            chk($sformatf("%s b%0d error", tag, b), int'(res_error), v.err[b]);
            chk($sformatf("%s b%0d fault", tag, b), int'(res_fault), int'(v.flt[b]));
            chk($sformatf("%s b%0d ovf",   tag, b), int'(res_ovf), 0);
            tick;
        end
        chk({tag, " valid end"}, int'(res_valid), 0);
        chk({tag, " busy end"},  int'(busy), 0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int chq [$];
        int bq  [$];
        int gn  [3][4];
        int exp_b [8];

        vecs[0].n = '{0, 11, 8, 0};   vecs[0].alt0 = 1'b1;
        vecs[0].cnt = '{10, 11, 8, 0};  vecs[0].err = '{0, 1, -2, -10};
        vecs[0].flt = '{1'b0, 1'b0, 1'b1, 1'b1};
        vecs[1].n = '{9, 20, 12, 1};  vecs[1].alt0 = 1'b0;
        vecs[1].cnt = '{9, 20, 12, 1};  vecs[1].err = '{-1, 10, 2, -9};
        vecs[1].flt = '{1'b0, 1'b1, 1'b1, 1'b1};
        vecs[2].n = '{10, 10, 10, 10}; vecs[2].alt0 = 1'b0;
        vecs[2].cnt = '{10, 10, 10, 10}; vecs[2].err = '{0, 0, 0, 0};
        vecs[2].flt = '{1'b0, 1'b0, 1'b0, 1'b0};
        vecs[3].n = '{11, 0, 20, 19}; vecs[3].alt0 = 1'b0;
        vecs[3].cnt = '{11, 0, 20, 19}; vecs[3].err = '{1, -10, 10, 9};
        vecs[3].flt = '{1'b0, 1'b1, 1'b1, 1'b1};
        v_ab.cnt = '{10, 0, 0, 0};  v_ab.err = '{0, -10, -10, -10};
        v_ab.flt = '{1'b0, 1'b1, 1'b1, 1'b1};
        v_bd.cnt = '{0, 0, 1, 0};   v_bd.err = '{-10, -10, -9, -10};
        v_bd.flt = '{1'b1, 1'b1, 1'b1, 1'b1};
        gn[0] = '{3, 4, 5, 6};
        gn[1] = '{7, 7, 7, 7};
        gn[2] = '{1, 2, 3, 4};
        exp_b = '{3, 4, 5, 6, 1, 2, 3, 4};

        rst = 1'b0; en = 1'b0; mode_cont = 1'b0; start = 1'b0; res_ready = 1'b0;
        ev_in = '0; s_start = 1'b0; s_ev = '0;
        #12;
        chk("rst valid",   int'(res_valid), 0);
        chk("rst busy",    int'(busy), 0);
        chk("rst overrun", int'(overrun), 0);
        chk("rst ch",      int'(res_ch), 0);
        chk("rst count",   int'(res_count), 0);
        chk("rst error",   int'(res_error), 0);
        chk("rst fault",   int'(res_fault), 0);
        chk("rst sat busy", int'(s_busy), 0);
        @(negedge clk);
        rst = 1'b1;

        // start is ignored while EN is low
        start = 1'b1;
        tick;
        chk("start ignored EN=0", int'(busy), 0);
        start = 1'b0;
        en = 1'b1;
        tick;

        // Table-driven single-shot gates
        for (int v = 0; v < 4; v++) begin
            fill_counts(vecs[v].n[0], vecs[v].n[1], vecs[v].n[2], vecs[v].n[3], vecs[v].alt0);
            run_gate(1'b0);
            chk($sformatf("v%0d busy hold", v), int'(busy), 1);
            drain_expect($sformatf("v%0d", v), vecs[v]);
        end

        // Saturation on the 4-bit instance
        s_start = 1'b1;
        s_ev = 4'b0001;
        tick;
        s_start = 1'b0;
        repeat (20) tick;
        s_ev = '0;
        chk("sat valid", int'(s_valid), 1);
        chk("sat count", int'(s_count), 15);
        chk("sat ovf",   int'(s_ovf), 1);
        chk("sat error", int'(s_error), 5);
        chk("sat fault", int'(s_fault), 1);
        res_ready = 1'b1;
        tick;
        chk("sat ch1 count", int'(s_count), 0);
        chk("sat ch1 ovf",   int'(s_ovf), 0);
        chk("sat ch1 error", int'(s_error), -10);
        repeat (3) tick;
        chk("sat drained", int'(s_valid), 0);

        // Backpressure on beat 1
        fill_counts(0, 11, 8, 0, 1'b1);
        run_gate(1'b0);
        chq.delete();
        res_ready = 1'b1;
        if (res_valid && res_ready) chq.push_back(int'(res_ch));
        tick;
        res_ready = 1'b0;
        for (int c = 0; c < 5; c++) begin
            tick;
            chk($sformatf("bp hold%0d valid", c), int'(res_valid), 1);
            chk($sformatf("bp hold%0d ch", c),    int'(res_ch), 1);
            chk($sformatf("bp hold%0d count", c), int'(res_count), 11);
            chk($sformatf("bp hold%0d error", c), int'(res_error), 1);
        end
        res_ready = 1'b1;
        for (int c = 0; c < 10 && res_valid; c++) begin
            if (res_ready) chq.push_back(int'(res_ch));
            tick;
        end
        chk("bp beats", chq.size(), 4);
        for (int i = 0; i < chq.size() && i < 4; i++) chk($sformatf("bp order%0d", i), chq[i], i);
        chk("bp busy end", int'(busy), 0);

        // Continuous mode with overrun on the second gate end
        chq.delete();
        bq.delete();
        mode_cont = 1'b1;
        res_ready = 1'b0;
        start = 1'b1;
        tick;
        start = 1'b0;
        for (int t = 1; t <= 70; t++) begin
            int g;
            int j;
            g = (t - 1) / 20;
            j = (t - 1) % 20 + 1;
            for (int i = 0; i < 4; i++) ev_in[i] = (g < 3) && (j <= gn[g < 3 ? g : 0][i]);
            res_ready = (t >= 46);
            if (res_valid && res_ready) begin
                bq.push_back(int'(res_count));
                chq.push_back(int'(res_ch));
            end
            tick;
            if (t == 39) chk("cont overrun before", int'(overrun), 0);
            if (t == 40) chk("cont overrun at gate2", int'(overrun), 1);
            if (t == 60) begin
                chk("cont g3 valid", int'(res_valid), 1);
                chk("cont g3 ch",    int'(res_ch), 0);
                chk("cont g3 count", int'(res_count), 1);
            end
            if (t == 70) chk("cont overrun sticky", int'(overrun), 1);
        end
        ev_in = '0;
        chk("cont beats", bq.size(), 8);
        for (int i = 0; i < bq.size() && i < 8; i++) begin
            chk($sformatf("cont beat%0d count", i), bq[i], exp_b[i]);
            chk($sformatf("cont beat%0d ch", i), chq[i], i % 4);
        end
        en = 1'b0;
        tick;
        chk("cont stop busy",    int'(busy), 0);
        chk("cont stop valid",   int'(res_valid), 0);
        chk("cont stop overrun", int'(overrun), 0);
        en = 1'b1;
        mode_cont = 1'b0;
        tick;

        // Abort at gate cycle 7, then a clean restart
        start = 1'b1;
        tick;
        start = 1'b0;
        ev_in = 4'b0001;
        repeat (6) tick;
        en = 1'b0;
        tick;
        chk("abort busy",  int'(busy), 0);
        chk("abort valid", int'(res_valid), 0);
        ev_in = '0;
        en = 1'b1;
        fill_counts(10, 0, 0, 0, 1'b0);
        run_gate(1'b0);
        drain_expect("abort", v_ab);

        // Gate boundaries: start-edge pulse ignored, last-edge pulse counted
        fill_counts(0, 0, 0, 0, 1'b0);
        ev_sched[0]  = 4'b0100;
        ev_sched[20] = 4'b0100;
        run_gate(1'b0);
        drain_expect("bound", v_bd);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
